// File: rtl/adc_mon_pkg.sv
// ============================================================================
//  adc_mon_pkg : shared types and constants for the ADC sample monitor
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package adc_mon_pkg;

    localparam int ADC_W = 12;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_MONITOR = 2'd1,
        ST_SUSPECT = 2'd2,
        ST_FAULT   = 2'd3
    } mon_state_t;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_UNDER = 2'b01;
    localparam logic [1:0] FC_OVER  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/adc_sample_monitor_if.sv
// ============================================================================
//  adc_sample_monitor_if : sample input, thresholds and monitor results
//  Revision              : 1.0
// ============================================================================
`default_nettype none

interface adc_sample_monitor_if;
    import adc_mon_pkg::*;

    logic [ADC_W-1:0] sample_in;
    logic             sample_valid;
    logic [ADC_W-1:0] lo_thresh;
    logic [ADC_W-1:0] hi_thresh;
    logic             clear_fault;
    logic [ADC_W-1:0] avg_out;
    logic             avg_valid;
    logic             fault;
    logic [1:0]       fault_code;
    logic [15:0]      sample_cnt;

    modport master (
        output sample_in, sample_valid, lo_thresh, hi_thresh, clear_fault,
        input  avg_out, avg_valid, fault, fault_code, sample_cnt
    );

    modport slave (
        input  sample_in, sample_valid, lo_thresh, hi_thresh, clear_fault,
        output avg_out, avg_valid, fault, fault_code, sample_cnt
    );

endinterface

`default_nettype wire

// File: rtl/adc_window_avg.sv
// ============================================================================
//  adc_window_avg : circular sample window with running sum and average
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module adc_window_avg
    import adc_mon_pkg::*;
#(
    parameter int WIN_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADC_W-1:0] sample_in,
    input  logic             sample_valid,
    output logic [ADC_W-1:0] avg_out,
    output logic             avg_valid,
    output logic             becomes_full
);

    localparam int DEPTH  = 1 << WIN_LOG2;
    localparam int SUM_W  = ADC_W + WIN_LOG2;
    localparam int FILL_W = WIN_LOG2 + 1;

    logic [ADC_W-1:0]    r_buf [DEPTH];
    logic [WIN_LOG2-1:0] r_ptr;
    logic [FILL_W-1:0]   r_fill;
    logic [SUM_W-1:0]    r_sum;
    logic [ADC_W-1:0]    r_avg;
    logic                r_avg_valid;

    logic                w_full;
    logic [ADC_W-1:0]    w_old;
    logic [SUM_W-1:0]    w_sum_next;

    assign w_full = (r_fill == FILL_W'(DEPTH));
    // Buffer is never cleared, so stale entries must not be subtracted while refilling.
    assign w_old        = w_full ? r_buf[r_ptr] : '0;
    assign w_sum_next   = r_sum + SUM_W'(sample_in) - SUM_W'(w_old);
    assign becomes_full = sample_valid && !w_full && (r_fill == FILL_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (sample_valid) begin
            r_buf[r_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_fill      <= '0;
            r_sum       <= '0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_valid <= 1'b0;
            if (sample_valid) begin
                r_ptr <= r_ptr + 1'b1;
                r_sum <= w_sum_next;
                if (!w_full) begin
                    r_fill <= r_fill + 1'b1;
                end
                if (w_full || becomes_full) begin
                    r_avg       <= w_sum_next[SUM_W-1:WIN_LOG2];
                    r_avg_valid <= 1'b1;
                end
            end
        end
    end

    assign avg_out   = r_avg;
    assign avg_valid = r_avg_valid;

endmodule

`default_nettype wire

// File: rtl/adc_sample_monitor.sv
// ============================================================================
//  adc_sample_monitor : windowed ADC average with range-fault detection
//  Revision           : 1.0
// ============================================================================
`default_nettype none

module adc_sample_monitor
    import adc_mon_pkg::*;
#(
    parameter int WIN_LOG2 = 3,
    parameter int FAIL_CNT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    adc_sample_monitor_if.slave  mon
);

    localparam int CNT_W = $clog2(FAIL_CNT + 1);

    logic [ADC_W-1:0] w_avg;
    logic             w_avg_valid;
    logic             w_becomes_full;

    mon_state_t       r_state, w_state_next;
    logic [CNT_W-1:0] r_run_cnt, w_run_cnt_next, w_run_inc;
    logic             r_fault, w_fault_next;
    logic [1:0]       r_fault_code, w_fault_code_next;
    logic [15:0]      r_sample_cnt;

    logic             w_under, w_over, w_oor;
    logic [1:0]       w_class;

    adc_window_avg #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_window (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (mon.sample_in),
        .sample_valid (mon.sample_valid),
        .avg_out      (w_avg),
        .avg_valid    (w_avg_valid),
        .becomes_full (w_becomes_full)
    );

    // Under is tested first, so inverted thresholds classify everything as out of range.
    assign w_under   = (w_avg < mon.lo_thresh);
    assign w_over    = !w_under && (w_avg > mon.hi_thresh);
    assign w_oor     = w_under || w_over;
    assign w_class   = w_under ? FC_UNDER : FC_OVER;
    assign w_run_inc = r_run_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FILL;
            r_run_cnt    <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
        end else begin
            r_state      <= w_state_next;
            r_run_cnt    <= w_run_cnt_next;
            r_fault      <= w_fault_next;
            r_fault_code <= w_fault_code_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_run_cnt_next    = r_run_cnt;
        w_fault_next      = r_fault;
        w_fault_code_next = r_fault_code;
        case (r_state)
            ST_FILL: begin
                if (w_becomes_full) begin
                    w_state_next = ST_MONITOR;
                end
            end
            ST_MONITOR, ST_SUSPECT: begin
                if (w_avg_valid) begin
                    if (w_oor) begin
                        w_run_cnt_next = w_run_inc;
                        if (w_run_inc >= CNT_W'(FAIL_CNT)) begin
                            w_state_next      = ST_FAULT;
                            w_fault_next      = 1'b1;
                            w_fault_code_next = w_class;
                        end else begin
                            w_state_next = ST_SUSPECT;
                        end
                    end else begin
                        w_state_next   = ST_MONITOR;
                        w_run_cnt_next = '0;
                    end
                end
            end
            ST_FAULT: begin
                if (mon.clear_fault) begin
                    w_state_next      = ST_MONITOR;
                    w_run_cnt_next    = '0;
                    w_fault_next      = 1'b0;
                    w_fault_code_next = FC_NONE;
                end
            end
            default: begin
                w_state_next = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample_cnt <= '0;
        end else if (mon.sample_valid && (r_sample_cnt != 16'hFFFF)) begin
            r_sample_cnt <= r_sample_cnt + 16'd1;
        end
    end

    assign mon.avg_out    = w_avg;
    assign mon.avg_valid  = w_avg_valid;
    assign mon.fault      = r_fault;
    assign mon.fault_code = r_fault_code;
    assign mon.sample_cnt = r_sample_cnt;

endmodule

`default_nettype wire

// File: tb/tb_adc_sample_monitor.sv
// ============================================================================
//  tb_adc_sample_monitor : directed vector bench for adc_sample_monitor
//  Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_adc_sample_monitor;
    import adc_mon_pkg::*;

    logic clk;
    logic rst;

    int total;
    int bad;

    adc_sample_monitor_if mon_if ();

    adc_sample_monitor #(
        .WIN_LOG2 (3),
        .FAIL_CNT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mon (mon_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] sample;
        logic        exp_valid;
        logic [11:0] exp_avg;
    } vec_t;

    vec_t vecs [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic send(input logic [11:0] v);
        mon_if.sample_in    = v;
        mon_if.sample_valid = 1'b1;
        step();
        mon_if.sample_valid = 1'b0;
    endtask

    // One sample under the given thresholds, plus an idle cycle so its average is judged.
    task automatic send_thr(input logic [11:0] lo, input logic [11:0] hi, input logic [11:0] v);
        mon_if.lo_thresh = lo;
        mon_if.hi_thresh = hi;
        send(v);
        step();
    endtask

    task automatic pulse_clear();
        mon_if.clear_fault = 1'b1;
        step();
        mon_if.clear_fault = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        mon_if.sample_in    = '0;
        mon_if.sample_valid = 1'b0;
        mon_if.lo_thresh    = 12'd0;
        mon_if.hi_thresh    = 12'd4095;
        mon_if.clear_fault  = 1'b0;

        for (int i = 0; i < 8; i++) begin
            vecs[i].sample    = 12'd1000;
            vecs[i].exp_valid = (i == 7);
            vecs[i].exp_avg   = 12'd1000;
            vecs[8+i].sample    = 12'd2000;
            vecs[8+i].exp_valid = 1'b1;
            vecs[8+i].exp_avg   = 12'(1125 + 125 * i);
        end

        // Reset state
        do_reset();
        chk("rst_avg_out",    32'(mon_if.avg_out),    32'd0);
        chk("rst_avg_valid",  32'(mon_if.avg_valid),  32'd0);
        chk("rst_fault",      32'(mon_if.fault),      32'd0);
        chk("rst_fault_code", 32'(mon_if.fault_code), 32'd0);
        chk("rst_sample_cnt", 32'(mon_if.sample_cnt), 32'd0);
        chk("rst_state",      32'(dut.r_state),       32'(ST_FILL));

        // Fill at 1000 then step to 2000 back to back
        for (int i = 0; i < 16; i++) begin
            mon_if.sample_in    = vecs[i].sample;
            mon_if.sample_valid = 1'b1;
            step();
            chk($sformatf("vec%0d_avg_valid", i), 32'(mon_if.avg_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d_avg_out", i), 32'(mon_if.avg_out), 32'(vecs[i].exp_avg));
            if (i == 7)
                chk("fill_state", 32'(dut.r_state), 32'(ST_MONITOR));
        end
        mon_if.sample_valid = 1'b0;
        step();
        chk("vec_idle_avg_valid", 32'(mon_if.avg_valid), 32'd0);
        chk("vec_sample_cnt",     32'(mon_if.sample_cnt), 32'd16);
        chk("vec_state",          32'(dut.r_state),       32'(ST_MONITOR));

        // Over-range run at 4000 leading to fault
        do_reset();
        mon_if.lo_thresh = 12'd500;
        mon_if.hi_thresh = 12'd3000;
        for (int i = 0; i < 8; i++) send(12'd4000);
        chk("ovr_first_avg", 32'(mon_if.avg_out), 32'd4000);
        step();
        chk("ovr_state1", 32'(dut.r_state),   32'(ST_SUSPECT));
        chk("ovr_cnt1",   32'(dut.r_run_cnt), 32'd1);
        send(12'd4000);
        send(12'd4000);
        step();
        chk("ovr_cnt3",   32'(dut.r_run_cnt), 32'd3);
        chk("ovr_fault3", 32'(mon_if.fault),  32'd0);
        send(12'd4000);
        chk("ovr_fault_pre", 32'(mon_if.fault), 32'd0);
        step();
        chk("ovr_fault",      32'(mon_if.fault),      32'd1);
        chk("ovr_fault_code", 32'(mon_if.fault_code), 32'(FC_OVER));
        chk("ovr_state",      32'(dut.r_state),       32'(ST_FAULT));
        for (int i = 0; i < 8; i++) send(12'd1000);
        step();
        chk("ovr_inrange_avg",   32'(mon_if.avg_out),    32'd1000);
        chk("ovr_held_fault",    32'(mon_if.fault),      32'd1);
        chk("ovr_held_code",     32'(mon_if.fault_code), 32'(FC_OVER));
        chk("ovr_sample_cnt",    32'(mon_if.sample_cnt), 32'd19);

        // Clear coincident with an out-of-range average
        mon_if.hi_thresh    = 12'd800;
        mon_if.sample_in    = 12'd1000;
        mon_if.sample_valid = 1'b1;
        step();
        mon_if.sample_valid = 1'b0;
        chk("clr_avg_valid", 32'(mon_if.avg_valid), 32'd1);
        pulse_clear();
        chk("clr_fault", 32'(mon_if.fault),      32'd0);
        chk("clr_code",  32'(mon_if.fault_code), 32'd0);
        chk("clr_state", 32'(dut.r_state),       32'(ST_MONITOR));
        chk("clr_cnt",   32'(dut.r_run_cnt),     32'd0);
        send_thr(12'd500, 12'd800, 12'd1000);
        pulse_clear();
        chk("clr_noeffect_state", 32'(dut.r_state),   32'(ST_SUSPECT));
        chk("clr_noeffect_cnt",   32'(dut.r_run_cnt), 32'd1);

        // Interrupted runs, equality, inverted thresholds, class change
        do_reset();
        mon_if.lo_thresh = 12'd0;
        mon_if.hi_thresh = 12'd4095;
        for (int i = 0; i < 8; i++) send(12'd1000);
        step();
        send_thr(12'd1000, 12'd1000, 12'd1000);
        chk("eq_state", 32'(dut.r_state), 32'(ST_MONITOR));
        for (int i = 0; i < 3; i++) send_thr(12'd0, 12'd900, 12'd1000);
        chk("run_a_cnt", 32'(dut.r_run_cnt), 32'd3);
        send_thr(12'd0, 12'd4095, 12'd1000);
        chk("run_break_state", 32'(dut.r_state),   32'(ST_MONITOR));
        chk("run_break_cnt",   32'(dut.r_run_cnt), 32'd0);
        for (int i = 0; i < 3; i++) send_thr(12'd1100, 12'd4095, 12'd1000);
        chk("run_b_fault", 32'(mon_if.fault),  32'd0);
        chk("run_b_state", 32'(dut.r_state),   32'(ST_SUSPECT));
        send_thr(12'd500, 12'd100, 12'd1000);
        chk("mix_fault", 32'(mon_if.fault),      32'd1);
        chk("mix_code",  32'(mon_if.fault_code), 32'(FC_OVER));
        pulse_clear();
        for (int i = 0; i < 4; i++) send_thr(12'd2000, 12'd100, 12'd1000);
        chk("inv_fault", 32'(mon_if.fault),      32'd1);
        chk("inv_code",  32'(mon_if.fault_code), 32'(FC_UNDER));

        // Reset mid-fill, coincident with a sample
        do_reset();
        mon_if.lo_thresh = 12'd0;
        mon_if.hi_thresh = 12'd4095;
        for (int i = 0; i < 5; i++) send(12'd1000);
        rst                 = 1'b1;
        mon_if.sample_in    = 12'd1000;
        mon_if.sample_valid = 1'b1;
        step();
        rst                 = 1'b0;
        mon_if.sample_valid = 1'b0;
        chk("mid_rst_cnt",   32'(mon_if.sample_cnt), 32'd0);
        chk("mid_rst_avg",   32'(mon_if.avg_out),    32'd0);
        chk("mid_rst_fault", 32'(mon_if.fault),      32'd0);
        chk("mid_rst_state", 32'(dut.r_state),       32'(ST_FILL));
        for (int i = 0; i < 7; i++) begin
            send(12'd300);
            chk($sformatf("refill%0d_valid", i), 32'(mon_if.avg_valid), 32'd0);
        end
        send(12'd300);
        chk("refill_valid", 32'(mon_if.avg_valid),  32'd1);
        chk("refill_avg",   32'(mon_if.avg_out),    32'd300);
        chk("refill_cnt",   32'(mon_if.sample_cnt), 32'd8);

        // Sample counter saturation
        do_reset();
        mon_if.sample_in    = 12'd300;
        mon_if.sample_valid = 1'b1;
        for (int i = 0; i < 65534; i++) step();
        chk("sat_fffe", 32'(mon_if.sample_cnt), 32'h0000FFFE);
        step();
        chk("sat_ffff", 32'(mon_if.sample_cnt), 32'h0000FFFF);
        step();
        step();
        chk("sat_hold", 32'(mon_if.sample_cnt), 32'h0000FFFF);
        chk("sat_avg",  32'(mon_if.avg_out),    32'd300);
        mon_if.sample_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
